// File: rtl/array_reader.sv
// array_reader: walks a run of words in a single-ported array and streams them out.
//   Latency: 3 cycles per word (REQ -> CAP -> OUT) with mem_ready and out_ready held high.
//   Backpressure: the output word and all other outputs freeze while out_ready is low.
//   In_ready is high only in IDLE. A command arriving while the reader is busy is dropped.
//
// Ports
//   clk, rst                      clock; asynchronous active-high reset
//   in_valid/in_ready             command handshake
//   in_base/in_len                start address and word count; in_len==0 only pulses done
//   out_valid/out_ready           read-data stream handshake
//   out_data/out_last             data word, and a flag marking the last word of a command
//   done                          one-cycle pulse after each command completes
//   mem_addr/mem_valid/mem_ready  array request; the address is held until accepted
//   mem_we/mem_di                 always zero, because the reader only reads
//   mem_do                        array read data, one cycle after mem_addr
//   sum                           running sum of streamed words; present only when
//                                 ARRAY_READER_SUM_EN is defined
//
// Optional feature macro: ARRAY_READER_SUM_EN

`ifndef AR_ADDR_W
`define AR_ADDR_W 8
`endif
`ifndef AR_DATA_W
`define AR_DATA_W 32
`endif
`ifndef addrT
`define addrT logic [`AR_ADDR_W-1:0]
`endif
`ifndef intT
`define intT logic [`AR_DATA_W-1:0]
`endif

module array_reader #(
    parameter int DEPTH = 16
) (
    input  logic   clk,
    input  logic   rst,
    // command side
    input  logic   in_valid,
    output logic   in_ready,
    input  `addrT  in_base,
    input  `addrT  in_len,
    // read-data stream
    output logic   out_valid,
    input  logic   out_ready,
    output `intT   out_data,
    output logic   out_last,
    output logic   done,
    // array request side
    output `addrT  mem_addr,
    output logic   mem_we,
    output `intT   mem_di,
    output logic   mem_valid,
    // array response side
    input  `intT   mem_do,
    input  logic   mem_ready
`ifdef ARRAY_READER_SUM_EN
    ,
    output `intT   sum
`endif
);

    localparam int AW = `AR_ADDR_W;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_CAP  = 2'd2;
    localparam logic [1:0] S_OUT  = 2'd3;

    localparam logic [AW-1:0] LP_DEPTH = AW'(DEPTH);
    localparam logic [AW-1:0] LP_ONE   = AW'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [1:0] r_state;
    `addrT      r_cur;       // address of the word currently in flight
    `addrT      r_rem;       // words still to deliver, including the current one
    `intT       r_out_data;
    logic       r_done;

    // ------------------------------------------------------------------
    // Decode
    // ------------------------------------------------------------------
    logic       w_in_fire;
    logic       w_out_fire;
    logic       w_zero_len;
    logic       w_last_word;
    `addrT      w_cur_inc;
    `addrT      w_cur_next;

    assign w_in_fire   = in_valid && (r_state == S_IDLE);
    assign w_out_fire  = (r_state == S_OUT) && out_ready;
    assign w_zero_len  = (in_len == '0);
    assign w_last_word = (r_rem == LP_ONE);

    // The address wraps at the array depth rather than at the natural width
    // of the address field.
    assign w_cur_inc   = r_cur + 1'b1;
    assign w_cur_next  = (w_cur_inc == LP_DEPTH) ? '0 : w_cur_inc;

    // ------------------------------------------------------------------
    // Control FSM and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_cur      <= '0;
            r_rem      <= '0;
            r_out_data <= '0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        if (w_zero_len) begin
                            // An empty command completes at once and never touches
                            // the array or the output stream.
                            r_done <= 1'b1;
                        end else begin
                            r_cur   <= in_base;
                            r_rem   <= in_len;
                            r_state <= S_REQ;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ready) begin
                        r_state <= S_CAP;
                    end
                end
                S_CAP: begin
                    // mem_do now holds the word addressed while in REQ.
                    r_out_data <= mem_do;
                    r_state    <= S_OUT;
                end
                S_OUT: begin
                    if (out_ready) begin
                        if (w_last_word) begin
                            r_done  <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_cur   <= w_cur_next;
                            r_rem   <= r_rem - 1'b1;
                            r_state <= S_REQ;
                        end
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // Every output comes from a register or from a decode of r_state. While
    // OUT is stalled nothing changes, so all outputs hold.
    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_OUT);
    assign out_last  = (r_state == S_OUT) && w_last_word;
    assign out_data  = r_out_data;
    assign done      = r_done;

    assign mem_valid = (r_state == S_REQ);
    assign mem_addr  = r_cur;
    assign mem_we    = 1'b0;
    assign mem_di    = '0;

`ifdef ARRAY_READER_SUM_EN
    // ------------------------------------------------------------------
    // Running sum of delivered words. It is cleared when a command is
    // accepted and holds its value after done until the next command.
    // ------------------------------------------------------------------
    `intT r_sum;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_sum <= '0;
        end else if (w_in_fire) begin
            r_sum <= '0;
        end else if (w_out_fire) begin
            r_sum <= r_sum + r_out_data;
        end
    end

    assign sum = r_sum;
`endif

endmodule

// File: tb/tb_array_reader.sv
module tb_array_reader;

    localparam int DEPTH = 16;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_base;
    logic [7:0]  in_len;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_last;
    logic        done;
    logic [7:0]  mem_addr;
    logic        mem_we;
    logic [31:0] mem_di;
    logic        mem_valid;
    logic [31:0] mem_do;
    logic        mem_ready;
`ifdef ARRAY_READER_SUM_EN
    logic [31:0] sum;
`endif

    array_reader #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_base   (in_base),
        .in_len    (in_len),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_last  (out_last),
        .done      (done),
        .mem_addr  (mem_addr),
        .mem_we    (mem_we),
        .mem_di    (mem_di),
        .mem_valid (mem_valid),
        .mem_do    (mem_do),
        .mem_ready (mem_ready)
`ifdef ARRAY_READER_SUM_EN
        ,
        .sum       (sum)
`endif
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Array model: registered read, one cycle after the address.
    logic [31:0] mem [DEPTH];
    always @(posedge clk) mem_do <= mem[mem_addr[3:0]];

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard: expected addresses, words and last flags, and one pending done.
    logic [7:0]  addr_q [$];
    logic [31:0] data_q [$];
    logic        last_q [$];
    logic        done_exp;
    logic [31:0] exp_sum;

    int  mr_mode;   // 0: toggle, 1: random, 2: always high
    bit  or_rand;
    bit  junk_en;

    task automatic tick();
        @(posedge clk);
        #1;
        case (mr_mode)
            0:       mem_ready = ~mem_ready;
            1:       mem_ready = 1'($urandom_range(0, 1));
            default: mem_ready = 1'b1;
        endcase
        if (or_rand) out_ready = ($urandom_range(0, 3) != 0);
    endtask

    task automatic issue(input logic [7:0] b, input logic [7:0] l);
        int g;
        g = 0;
        while (data_q.size() != 0 && g < 600) begin
            if (junk_en) begin
                // The DUT is busy, so these commands must be ignored.
                in_valid = ($urandom_range(0, 2) == 0);
                in_base  = 8'($urandom);
                in_len   = 8'($urandom);
            end
            tick();
            g++;
        end
        if (data_q.size() != 0) chk("idle_wait_timeout", 64'(1), 64'(0));
        in_valid = 1'b1;
        in_base  = b;
        in_len   = l;
        tick();
        in_valid = 1'b0;
        in_base  = 8'($urandom);
        in_len   = 8'($urandom);
        exp_sum  = '0;
        if (l == 0) begin
            done_exp = 1'b1;
        end else begin
            for (int k = 0; k < int'(l); k++) begin
                int a;
                a = (int'(b) + k) % DEPTH;
                addr_q.push_back(8'(a));
                data_q.push_back(mem[a]);
                last_q.push_back(k == int'(l) - 1);
            end
        end
    endtask

    task automatic drain();
        int g;
        g = 0;
        while (data_q.size() != 0 && g < 2000) begin
            tick();
            g++;
        end
        if (data_q.size() != 0) chk("drain_timeout", 64'(1), 64'(0));
        tick();
        tick();
    endtask

    // Monitor: compares every cycle, on the falling edge.
    logic        hold_prev;
    logic [31:0] hold_data;
    logic        hold_last;
    initial begin
        logic [31:0] ed;
        logic        el;
        hold_prev = 1'b0;
        hold_data = '0;
        hold_last = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                hold_prev = 1'b0;
            end else begin
                chk("in_ready", 64'(in_ready), 64'(data_q.size() == 0));
                chk("mem_we_di", 64'({mem_we, mem_di}), 64'(0));
                chk("done", 64'(done), 64'(done_exp));
`ifdef ARRAY_READER_SUM_EN
                if (done_exp) chk("sum", 64'(sum), 64'(exp_sum));
`endif
                done_exp = 1'b0;
                if (!out_valid) chk("last_idle", 64'(out_last), 64'(0));
                if (hold_prev) begin
                    chk("hold_valid", 64'(out_valid), 64'(1));
                    chk("hold_data", 64'(out_data), 64'(hold_data));
                    chk("hold_last", 64'(out_last), 64'(hold_last));
                end
                hold_prev = out_valid && !out_ready;
                hold_data = out_data;
                hold_last = out_last;
                if (mem_valid) begin
                    if (addr_q.size() == 0) begin
                        chk("mem_valid_unexpected", 64'(1), 64'(0));
                    end else begin
                        chk("mem_addr", 64'(mem_addr), 64'(addr_q[0]));
                        if (mem_ready) void'(addr_q.pop_front());
                    end
                end
                if (out_valid && out_ready) begin
                    if (data_q.size() == 0) begin
                        chk("out_valid_unexpected", 64'(1), 64'(0));
                    end else begin
                        ed = data_q.pop_front();
                        el = last_q.pop_front();
                        chk("out_data", 64'(out_data), 64'(ed));
                        chk("out_last", 64'(out_last), 64'(el));
                        exp_sum = exp_sum + ed;
                        if (el) done_exp = 1'b1;
                    end
                end
            end
        end
    end

    initial begin
        int g;
        int n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_base   = '0;
        in_len    = '0;
        out_ready = 1'b1;
        mem_ready = 1'b0;
        mr_mode   = 0;
        or_rand   = 1'b0;
        junk_en   = 1'b0;
        done_exp  = 1'b0;
        exp_sum   = '0;
        for (int i = 0; i < DEPTH; i++) mem[i] = 32'(i);

        #1;
        chk("rst_in_ready", 64'(in_ready), 64'(1));
        chk("rst_out_valid", 64'(out_valid), 64'(0));
        chk("rst_out_last", 64'(out_last), 64'(0));
        chk("rst_done", 64'(done), 64'(0));
        chk("rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("rst_out_data", 64'(out_data), 64'(0));
        tick();
        tick();
        #2 rst = 1'b0;

        // Plain run, accepted on the first edge after reset.
        issue(8'd3, 8'd4);
        drain();
        // Address wraps at DEPTH.
        issue(8'd14, 8'd4);
        drain();
        // Empty command: done only.
        issue(8'd7, 8'd0);
        drain();

        // First word stalled for five cycles.
        out_ready = 1'b0;
        issue(8'd5, 8'd2);
        g = 0;
        while (!out_valid && g < 50) begin
            tick();
            g++;
        end
        chk("stall_reach_out", 64'(out_valid), 64'(1));
        for (int i = 0; i < 5; i++) begin
            chk("stall_data", 64'(out_data), 64'(5));
            tick();
        end
        out_ready = 1'b1;
        drain();

        // Throughput with both sides always ready: one word per 3 cycles.
        mr_mode   = 2;
        mem_ready = 1'b1;
        issue(8'd0, 8'd6);
        n = 0;
        while (data_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        chk("throughput_cycles", 64'(n), 64'(18));
        drain();
        mr_mode = 0;

        // Reset in the middle of a command.
        issue(8'd0, 8'd8);
        g = 0;
        while (!mem_valid && g < 20) begin
            tick();
            g++;
        end
        chk("reached_req", 64'(mem_valid), 64'(1));
        #2 rst = 1'b1;
        addr_q.delete();
        data_q.delete();
        last_q.delete();
        done_exp = 1'b0;
        exp_sum  = '0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready), 64'(1));
        chk("mid_rst_out_valid", 64'(out_valid), 64'(0));
        chk("mid_rst_out_last", 64'(out_last), 64'(0));
        chk("mid_rst_done", 64'(done), 64'(0));
        chk("mid_rst_mem_valid", 64'(mem_valid), 64'(0));
        chk("mid_rst_mem_addr", 64'(mem_addr), 64'(0));
        chk("mid_rst_out_data", 64'(out_data), 64'(0));
        tick();
        #2 rst = 1'b0;
        issue(8'd2, 8'd1);
        drain();

`ifdef ARRAY_READER_SUM_EN
        issue(8'd0, 8'd16);
        drain();
        chk("sum_0_to_15", 64'(sum), 64'(120));
`endif

        // Randomised commands, array contents, ready patterns and ignored commands.
        for (int i = 0; i < DEPTH; i++) mem[i] = $urandom;
        mr_mode = 1;
        or_rand = 1'b1;
        junk_en = 1'b1;
        for (int c = 0; c < 30; c++) begin
            issue(8'($urandom_range(0, DEPTH - 1)), 8'($urandom_range(0, 20)));
        end
        junk_en  = 1'b0;
        in_valid = 1'b0;
        drain();
        chk("end_queue_empty", 64'(data_q.size()), 64'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
